pulse_event_builder: RTL and testbench
======================================

Name: pulse_event_builder

Overview:
- Sits directly downstream of the threshold sampler: consumes its 10-bit sample stream (data plus write-enable, asserted only while the ADC is above threshold).
- Groups each contiguous run of valid samples into one pulse event and computes peak amplitude, integrated sum, length and start timestamp.
- Queues completed event records in a small FIFO for the readout/DMA stage, using a valid/ready handshake.

Parameters:
- DATA_W, 10, sample width.
- SUM_W, 20, integrated-sum width (saturating).
- LEN_W, 8, event length width (saturating).
- TS_W, 32, timestamp width (wrapping).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, at least 2).
- MIN_LEN, 2, minimum run length kept as an event; shorter runs are glitches.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  DATA_W  sample from sampler.
- din_we  in  1  sample valid (high while above threshold).
- ev_ready  in  1  downstream accepts record.
- ev_valid  out  1  record available at FIFO head.
- ev_peak  out  DATA_W  max sample of event.
- ev_sum  out  SUM_W  sum of samples.
- ev_len  out  LEN_W  number of samples.
- ev_ts  out  TS_W  timestamp of first sample.
- ev_trunc  out  1  len or sum saturated.
- ev_drop_cnt  out  16  events lost to a full FIFO (saturating).
- busy  out  1  event accumulation in progress.

Behaviour:
- Reset (async assert, sync release): state IDLE, timestamp 0, accumulators 0, FIFO empty. All outputs 0: ev_valid=0, record fields 0, ev_drop_cnt=0, busy=0. A partial event in progress is discarded.
- Timestamp: free-running counter, +1 every clk, wraps 2^TS_W-1 -> 0.
- State machine, IDLE:
  - din_we=1 -> ACCUM; ts_r=timestamp, peak=din, sum=din, len=1, trunc=0.
  - Otherwise stay in IDLE.
- State machine, ACCUM:
  - din_we=1: peak=max(peak,din); sum=sum+din, saturating at all-ones; len+1, saturating at all-ones. Any saturation sets trunc. Stay in ACCUM.
  - din_we=0 (close): if len>=MIN_LEN, push {trunc,ts,len,sum,peak}; else discard silently (drop_cnt unaffected). Go to IDLE on the same edge.
  - Zero dead time: a new event can start on the cycle immediately after the close cycle.
- busy=1 exactly while in ACCUM.
- Push when FIFO full:
  - Without a pop in the same cycle: record dropped, ev_drop_cnt+1 (saturating at 65535).
  - With a pop in the same cycle (ev_valid & ev_ready): push accepted, occupancy unchanged.
- FIFO is first-word-fall-through:
  - ev_valid = not empty; record fields show the head entry.
  - Pop on ev_valid & ev_ready.
  - Record fields hold stable while ev_valid=1 and ev_ready=0.
- Latency: if the first din_we=0 is sampled at edge N, ev_valid=1 from edge N+1 (FIFO previously empty).
- Arithmetic: din is zero-extended to SUM_W before adding; comparisons are unsigned.
- din is ignored while din_we=0.

Decomposition:
- Package fads_daq_pkg:
  - DATA_W, SUM_W, LEN_W, TS_W constants.
  - Packed event record typedef (trunc, ts, len, sum, peak, MSB to LSB).
  - State enum {IDLE, ACCUM}.
- Sub-module event_fifo: parameterised by depth and record width; push/pop/full/empty, FWFT output, same-cycle push-when-full-with-pop rule.
- Accumulator and FSM stay in the top module.

Test Plan:
- Samples 150,300,220,120 with din_we=1, then din_we=0, ev_ready=1 -> one record: peak=300, sum=790, len=4, trunc=0, ts=timestamp at first sample; ev_valid high for exactly 1 cycle.
- Single-cycle din_we pulse (din=500), MIN_LEN=2 -> no record, ev_valid stays 0, ev_drop_cnt=0.
- ev_ready=0, 9 events of length 3 -> 8 held, ev_drop_cnt=1. Then ev_ready=1 drains 8 records in order with increasing ts; ninth event absent.
- 1100 consecutive samples of 1023 -> len=255, sum=1048575, trunc=1.
- Two 3-sample events separated by a 1-cycle gap -> two records, second ts = first ts+4, both len=3.
- rst_n low mid-event (len=5) then released -> no record emitted, all outputs 0, next event timestamps restart from 0.

Source files
------------

// File: rtl/fads_daq_pkg.sv
// Shared widths, event record layout and FSM state encoding for the pulse
// event builder datapath.
package fads_daq_pkg;

  localparam int DATA_W = 10;
  localparam int SUM_W  = 20;
  localparam int LEN_W  = 8;
  localparam int TS_W   = 32;
  localparam int DROP_W = 16;

  // Completed pulse record, MSB to LSB: trunc, ts, len, sum, peak.
  typedef struct packed {
    logic              trunc;
    logic [TS_W-1:0]   ts;
    logic [LEN_W-1:0]  len;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] peak;
  } ev_rec_t;

  localparam int REC_W = $bits(ev_rec_t);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through record FIFO. A push into a full FIFO is accepted
// only when a pop happens on the same edge; otherwise push_ok stays low so
// the caller can count the loss.
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero while empty so the record outputs read 0 after reset.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_event_builder.sv
// Groups contiguous runs of above-threshold samples into pulse events
// (peak, saturating sum and length, start timestamp) and queues the
// finished records for readout.
//
// state | meaning
// IDLE  | no run in progress, waiting for din_we
// ACCUM | run in progress, accumulating peak/sum/len
module pulse_event_builder
  import fads_daq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_LEN    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_we,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic [DATA_W-1:0] ev_peak,
  output logic [SUM_W-1:0]  ev_sum,
  output logic [LEN_W-1:0]  ev_len,
  output logic [TS_W-1:0]   ev_ts,
  output logic              ev_trunc,
  output logic [DROP_W-1:0] ev_drop_cnt,
  output logic              busy
);

  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);

  state_e            state_q;
  state_e            state_d;
  logic              start;
  logic              accum;
  logic              push;
  logic              push_ok;
  logic              fifo_full;
  logic              fifo_empty;

  logic [TS_W-1:0]   ts_cnt;
  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] peak_q;
  logic [SUM_W-1:0]  sum_q;
  logic [LEN_W-1:0]  len_q;
  logic              trunc_q;
  logic [DROP_W-1:0] drop_q;

  logic [SUM_W:0]    sum_add;
  logic [SUM_W-1:0]  sum_sat;
  logic              sum_ovf;
  logic              len_full;
  logic [LEN_W-1:0]  len_nxt;

  ev_rec_t           push_rec;
  ev_rec_t           head_rec;
  logic [REC_W-1:0]  head_bits;

  // Free-running wrapping timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and event start/continue/close decode.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    accum   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_we) begin
          start   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (din_we) begin
          accum = 1'b1;
        end else begin
          // Runs shorter than MIN_LEN are glitches and vanish without a count.
          push    = (len_q >= MIN_LEN_L);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum_add  = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, din};
  assign sum_ovf  = sum_add[SUM_W];
  assign sum_sat  = sum_ovf ? {SUM_W{1'b1}} : sum_add[SUM_W-1:0];
  assign len_full = &len_q;
  assign len_nxt  = len_full ? len_q : len_q + 1'b1;

  // Event accumulators: load on the first sample, fold in following samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      peak_q  <= '0;
      sum_q   <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else if (start) begin
      ts_q    <= ts_cnt;
      peak_q  <= din;
      sum_q   <= {{(SUM_W - DATA_W){1'b0}}, din};
      len_q   <= LEN_W'(1);
      trunc_q <= 1'b0;
    end else if (accum) begin
      if (din > peak_q) peak_q <= din;
      sum_q   <= sum_sat;
      len_q   <= len_nxt;
      trunc_q <= trunc_q | sum_ovf | len_full;
    end
  end

  // Saturating count of records refused by a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (push && !push_ok && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  always_comb begin
    push_rec       = '0;
    push_rec.trunc = trunc_q;
    push_rec.ts    = ts_q;
    push_rec.len   = len_q;
    push_rec.sum   = sum_q;
    push_rec.peak  = peak_q;
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rec),
    .pop       (ev_ready),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok)
  );

  assign head_rec    = ev_rec_t'(head_bits);
  assign ev_valid    = !fifo_empty;
  assign ev_peak     = head_rec.peak;
  assign ev_sum      = head_rec.sum;
  assign ev_len      = head_rec.len;
  assign ev_ts       = head_rec.ts;
  assign ev_trunc    = head_rec.trunc;
  assign ev_drop_cnt = drop_q;
  assign busy        = (state_q == ACCUM);

  // fifo_full is only consumed inside the FIFO's push_ok decision.
  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_pulse_event_builder.sv
// Scoreboard bench for pulse_event_builder: a behavioural model predicts the
// records entering the FIFO; the head is compared every cycle and popped
// when the bench asserts ev_ready.
module tb_pulse_event_builder;
  import fads_daq_pkg::*;

  localparam int DEPTH = 8;
  localparam int MINL  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_we = 1'b0;
  logic              ev_ready = 1'b0;
  logic              ev_valid;
  logic [DATA_W-1:0] ev_peak;
  logic [SUM_W-1:0]  ev_sum;
  logic [LEN_W-1:0]  ev_len;
  logic [TS_W-1:0]   ev_ts;
  logic              ev_trunc;
  logic [DROP_W-1:0] ev_drop_cnt;
  logic              busy;

  pulse_event_builder #(.FIFO_DEPTH(DEPTH), .MIN_LEN(MINL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_we      (din_we),
    .ev_ready    (ev_ready),
    .ev_valid    (ev_valid),
    .ev_peak     (ev_peak),
    .ev_sum      (ev_sum),
    .ev_len      (ev_len),
    .ev_ts       (ev_ts),
    .ev_trunc    (ev_trunc),
    .ev_drop_cnt (ev_drop_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  peak;
    logic [19:0] sum;
    logic [7:0]  len;
    logic        trunc;
    logic [31:0] ts;
  } mrec_t;

  int checks = 0;
  int errors = 0;

  mrec_t exp_q[$];
  mrec_t dut_last;
  mrec_t dut_prev;
  int    pops = 0;

  bit          m_acc = 0;
  int          m_peak, m_sum, m_len;
  bit          m_trunc;
  logic [31:0] m_ts;
  logic [31:0] ts_model = '0;
  int          drop_model = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check head against the model, advance the model.
  task automatic tick(input bit we, input int d, input bit rdy);
    bit    popped;
    mrec_t r;
    din_we   = we;
    din      = d[9:0];
    ev_ready = rdy;
    #1;
    chk("ev_valid", ev_valid, exp_q.size() != 0);
    chk("busy", busy, m_acc);
    chk("drop_cnt", ev_drop_cnt, drop_model);
    popped = 0;
    if (exp_q.size() != 0) begin
      chk("peak",  ev_peak,  exp_q[0].peak);
      chk("sum",   ev_sum,   exp_q[0].sum);
      chk("len",   ev_len,   exp_q[0].len);
      chk("trunc", ev_trunc, exp_q[0].trunc);
      chk("ts",    ev_ts,    exp_q[0].ts);
      if (rdy) begin
        void'(exp_q.pop_front());
        dut_prev = dut_last;
        dut_last.peak  = ev_peak;
        dut_last.sum   = ev_sum;
        dut_last.len   = ev_len;
        dut_last.trunc = ev_trunc;
        dut_last.ts    = ev_ts;
        pops++;
        popped = 1;
      end
    end
    if (m_acc && !we) begin
      if (m_len >= MINL) begin
        r.peak = m_peak[9:0]; r.sum = m_sum[19:0]; r.len = m_len[7:0];
        r.trunc = m_trunc; r.ts = m_ts;
        if (exp_q.size() < DEPTH || popped) exp_q.push_back(r);
        else if (drop_model < 65535) drop_model++;
      end
      m_acc = 0;
    end else if (m_acc && we) begin
      if (d > m_peak) m_peak = d;
      if (m_sum + d > 1048575) begin m_sum = 1048575; m_trunc = 1; end
      else m_sum = m_sum + d;
      if (m_len == 255) m_trunc = 1;
      else m_len++;
    end else if (we) begin
      m_acc = 1; m_peak = d; m_sum = d; m_len = 1; m_trunc = 0; m_ts = ts_model;
    end
    @(posedge clk);
    ts_model = ts_model + 1;
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, ev_valid, 0);
    chk({tag, "_fields"}, {ev_peak, ev_sum, ev_len, ev_trunc, ev_ts[21:0]}, 0);
    chk({tag, "_ts_hi"}, ev_ts, 0);
    chk({tag, "_drop"}, ev_drop_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    logic [31:0] t0;
    int          smp[4];
    smp = '{150, 300, 220, 120};

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // Basic four-sample event.
    p0 = pops; t0 = ts_model;
    for (int i = 0; i < 4; i++) tick(1, smp[i], 1);
    repeat (4) tick(0, 0, 1);
    chk("t1_pops", pops - p0, 1);
    chk("t1_peak", dut_last.peak, 300);
    chk("t1_sum", dut_last.sum, 790);
    chk("t1_len", dut_last.len, 4);
    chk("t1_trunc", dut_last.trunc, 0);
    chk("t1_ts", dut_last.ts, t0);

    // Single-sample glitch is discarded silently.
    p0 = pops;
    tick(1, 500, 1);
    repeat (4) tick(0, 0, 1);
    chk("t2_pops", pops - p0, 0);
    chk("t2_drop", ev_drop_cnt, 0);

    // Nine 3-sample events into a stalled FIFO: one dropped.
    for (int e = 0; e < 9; e++) begin
      for (int k = 1; k <= 3; k++) tick(1, e * 10 + k, 0);
      tick(0, 0, 0);
    end
    tick(0, 0, 0);
    chk("t3_drop", ev_drop_cnt, 1);
    p0 = pops;
    repeat (10) tick(0, 0, 1);
    chk("t3_pops", pops - p0, 8);
    chk("t3_last_peak", dut_last.peak, 73);
    chk("t3_ts_order", dut_last.ts - dut_prev.ts, 4);

    // Long saturating run.
    for (int i = 0; i < 1100; i++) tick(1, 1023, 1);
    repeat (3) tick(0, 0, 1);
    chk("t4_len", dut_last.len, 255);
    chk("t4_sum", dut_last.sum, 1048575);
    chk("t4_trunc", dut_last.trunc, 1);
    chk("t4_peak", dut_last.peak, 1023);

    // Back-to-back events with a one-cycle gap.
    p0 = pops; t0 = ts_model;
    for (int k = 0; k < 3; k++) tick(1, 40 + k, 1);
    tick(0, 0, 1);
    for (int k = 0; k < 3; k++) tick(1, 60 + k, 1);
    repeat (3) tick(0, 0, 1);
    chk("t5_pops", pops - p0, 2);
    chk("t5_ts0", dut_prev.ts, t0);
    chk("t5_ts_gap", dut_last.ts - dut_prev.ts, 4);
    chk("t5_len0", dut_prev.len, 3);
    chk("t5_len1", dut_last.len, 3);

    // Reset in the middle of a 5-sample run.
    for (int k = 0; k < 5; k++) tick(1, 100 + k, 1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    exp_q.delete();
    m_acc = 0; drop_model = 0; ts_model = '0;
    @(negedge clk);
    chk_zero_outputs("midrst_hold");
    rst_n = 1'b1;
    p0 = pops;
    for (int k = 0; k < 3; k++) tick(1, 7 + k, 1);
    repeat (3) tick(0, 0, 1);
    chk("t6_pops", pops - p0, 1);
    chk("t6_ts", dut_last.ts, 0);
    chk("t6_len", dut_last.len, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
